// File: rtl/signed_divider_seq_pkg.sv
// Shared definitions for the sequential signed divider: FSM states and
// the step-counter sizing helper.
package signed_divider_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH itself.
    function automatic int unsigned cnt_bits(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/signed_divider_seq_if.sv
// Request/result bundle for the sequential signed divider.
interface signed_divider_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;
    logic             overflow;
    logic             negative;
    logic             zero;

    modport master (
        output start, x, y,
        input  busy, done, q, r, div_by_zero, overflow, negative, zero
    );

    modport slave (
        input  start, x, y,
        output busy, done, q, r, div_by_zero, overflow, negative, zero
    );
endinterface

// File: rtl/signed_divider_seq_adder.sv
// Simplified adder/subtractor shared with the ALU datapath; with add_sub=1
// it computes a - b and cout=1 indicates no borrow.
module simplified_signed_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   total;

    assign b_eff = b ^ {WIDTH{add_sub}};
    assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_sub};
    assign sum   = total[WIDTH-1:0];
    assign cout  = total[WIDTH];
endmodule

// File: rtl/signed_divider_seq.sv
// Iterative restoring signed divider: one quotient bit per clock on
// operand magnitudes, signs reapplied when the result is registered.
module signed_divider_seq
    import signed_divider_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    signed_divider_seq_if.slave bus
);
    localparam int unsigned      CNT_W     = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             sign_x;
    logic             sign_y;
    logic             ovf_pend;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             dbz_reg;
    logic             ovf_reg;

    logic             accept;
    logic             finish;
    logic             y_zero;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;
    logic             unused_rem_msb;

    // Magnitudes are unsigned, so |most-negative| still fits in WIDTH bits.
    always_comb begin
        x_mag  = bus.x[WIDTH-1] ? -bus.x : bus.x;
        y_mag  = bus.y[WIDTH-1] ? -bus.y : bus.y;
        y_zero = (bus.y == '0);
    end

    assign shifted        = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign unused_rem_msb = rem[WIDTH];

    simplified_signed_adder #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .a       (shifted),
        .b       ({1'b0, dvs}),
        .add_sub (1'b1),
        .sum     (diff),
        .cout    (no_borrow)
    );

    always_comb begin
        rem_next = no_borrow ? diff : shifted;
        q_mag    = {dvd[WIDTH-2:0], no_borrow};
        r_mag    = rem_next[WIDTH-1:0];
        q_signed = (sign_x ^ sign_y) ? -q_mag : q_mag;
        r_signed = sign_x ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = y_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_STEP) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Dividend register shifts out its MSB each step while quotient bits
    // shift in at the bottom, so it ends up holding the magnitude quotient.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            sign_x   <= 1'b0;
            sign_y   <= 1'b0;
            ovf_pend <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            dbz_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= x_mag;
            dvs      <= y_mag;
            sign_x   <= bus.x[WIDTH-1];
            sign_y   <= bus.y[WIDTH-1];
            ovf_pend <= (bus.x == MOST_NEG) && (bus.y == '1);
            if (y_zero) begin
                q_reg   <= '1;
                r_reg   <= bus.x;
                dbz_reg <= 1'b1;
                ovf_reg <= 1'b0;
            end
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            rem <= rem_next;
            dvd <= q_mag;
            if (finish) begin
                q_reg   <= q_signed;
                r_reg   <= r_signed;
                dbz_reg <= 1'b0;
                ovf_reg <= ovf_pend;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.q           = q_reg;
    assign bus.r           = r_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.overflow    = ovf_reg;
    assign bus.negative    = q_reg[WIDTH-1];
    assign bus.zero        = (q_reg == '0);

endmodule

// File: tb/tb_signed_divider_seq.sv
// Directed self-checking bench for signed_divider_seq (WIDTH=8); result
// vectors are packed as {q, r, div_by_zero, overflow, negative, zero}.
module tb_signed_divider_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    signed_divider_seq_if #(.WIDTH(W)) bus ();

    signed_divider_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [W-1:0]     sgn_x [3] = '{8'h9C, 8'h64, 8'h9C};
    logic [W-1:0]     sgn_y [3] = '{8'h07, 8'hF9, 8'hF9};
    logic [2*W+3:0]   sgn_e [3] = '{{8'hF2, 8'hFE, 4'b0010},
                                    {8'hF2, 8'h02, 4'b0010},
                                    {8'h0E, 8'hFE, 4'b0000}};

    function automatic logic [2*W+3:0] outs();
        return {bus.q, bus.r, bus.div_by_zero, bus.overflow, bus.negative, bus.zero};
    endfunction

    // Issues one start pulse; lat counts falling edges after the accepting
    // edge until done is seen (-1 on timeout).
    task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         output int lat, output logic busy0);
        @(negedge clk);
        bus.x = xv; bus.y = yv; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        @(negedge clk);
        busy0 = bus.busy;
        while (!bus.done && lat <= 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) begin
            tests++; fails++;
            $display("FAIL op_timeout: done=%0b required 1 (x=%h y=%h)", bus.done, xv, yv);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.x = '0; bus.y = '0;
        resetn = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done, outs()} !== {2'b00, 8'h00, 8'h00, 4'b0001}) begin
            fails++;
            $display("FAIL reset_state: got %h required %h", {bus.busy, bus.done, outs()},
                     {2'b00, 8'h00, 8'h00, 4'b0001});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic b0;
        do_op(8'd100, 8'd7, lat, b0);
        tests++;
        if (b0 !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", b0); end
        tests++;
        if (lat !== W) begin fails++; $display("FAIL basic_latency: got %0d required %0d", lat, W); end
        tests++;
        if (outs() !== {8'd14, 8'd2, 4'b0000}) begin
            fails++; $display("FAIL basic_result: got %h required %h", outs(), {8'd14, 8'd2, 4'b0000});
        end
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++; $display("FAIL basic_pulse: busy/done got %b required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_signs();
        int lat; logic b0;
        for (int i = 0; i < 3; i++) begin
            do_op(sgn_x[i], sgn_y[i], lat, b0);
            tests++;
            if (outs() !== sgn_e[i]) begin
                fails++;
                $display("FAIL signs_%0d: got %h required %h", i, outs(), sgn_e[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int lat; logic b0;
        do_op(8'h80, 8'hFF, lat, b0);
        tests++;
        if ({lat == W, outs()} !== {1'b1, 8'h80, 8'h00, 4'b0110}) begin
            fails++; $display("FAIL overflow_case: lat=%0d got %h required %h", lat, outs(),
                              {8'h80, 8'h00, 4'b0110});
        end
        do_op(8'h80, 8'h01, lat, b0);
        tests++;
        if (outs() !== {8'h80, 8'h00, 4'b0010}) begin
            fails++; $display("FAIL min_div_one: got %h required %h", outs(), {8'h80, 8'h00, 4'b0010});
        end
    endtask

    task automatic test_div_zero();
        int lat; logic b0;
        do_op(8'd5, 8'd0, lat, b0);
        tests++;
        if (lat !== 0) begin fails++; $display("FAIL dbz_latency: got %0d required 0", lat); end
        tests++;
        if (outs() !== {8'hFF, 8'h05, 4'b1010}) begin
            fails++; $display("FAIL dbz_result: got %h required %h", outs(), {8'hFF, 8'h05, 4'b1010});
        end
        do_op(8'd6, 8'd3, lat, b0);
        tests++;
        if ({lat == W, outs()} !== {1'b1, 8'h02, 8'h00, 4'b0000}) begin
            fails++; $display("FAIL dbz_clear: lat=%0d got %h required %h", lat, outs(),
                              {8'h02, 8'h00, 4'b0000});
        end
    endtask

    task automatic test_zero_dividend();
        int lat; logic b0;
        do_op(8'd0, 8'd9, lat, b0);
        tests++;
        if ({lat == W, outs()} !== {1'b1, 8'h00, 8'h00, 4'b0001}) begin
            fails++; $display("FAIL zero_dividend: lat=%0d got %h required %h", lat, outs(),
                              {8'h00, 8'h00, 4'b0001});
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        bus.x = 8'd100; bus.y = 8'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.done && lat <= 40) begin
            if (lat == 2) begin
                bus.start = 1'b1; bus.x = 8'd1; bus.y = 8'd1;
            end else if (lat == 3) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        tests++;
        if ({bus.done, lat == W, outs()} !== {2'b11, 8'd14, 8'd2, 4'b0000}) begin
            fails++; $display("FAIL ignore_start: done=%b lat=%0d got %h required %h", bus.done, lat,
                              outs(), {8'd14, 8'd2, 4'b0000});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int gap;
        int wait_cnt;
        @(negedge clk);
        bus.x = 8'd100; bus.y = 8'd7; bus.start = 1'b1;
        wait_cnt = 0;
        @(negedge clk);
        while (!bus.done && wait_cnt <= 40) begin @(negedge clk); wait_cnt++; end
        tests++;
        if ({bus.done, outs()} !== {1'b1, 8'd14, 8'd2, 4'b0000}) begin
            fails++; $display("FAIL b2b_first: done=%b got %h required %h", bus.done, outs(),
                              {8'd14, 8'd2, 4'b0000});
        end
        bus.x = 8'd6; bus.y = 8'd3;
        gap = 1;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            fails++; $display("FAIL b2b_idle_gap: busy/done got %b required 00", {bus.busy, bus.done});
        end
        while (!bus.done && gap <= 40) begin @(negedge clk); gap++; end
        bus.start = 1'b0;
        tests++;
        if ({gap == W + 2, outs()} !== {1'b1, 8'd2, 8'd0, 4'b0000}) begin
            fails++; $display("FAIL b2b_second: gap=%0d got %h required gap %0d %h", gap, outs(),
                              W + 2, {8'd2, 8'd0, 4'b0000});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat; logic b0;
        int seen;
        @(negedge clk);
        bus.x = 8'd100; bus.y = 8'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done, outs()} !== {2'b00, 8'h00, 8'h00, 4'b0001}) begin
            fails++; $display("FAIL async_reset: got %h required %h", {bus.busy, bus.done, outs()},
                              {2'b00, 8'h00, 8'h00, 4'b0001});
        end
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL reset_no_resume: active cycles got %0d required 0", seen); end
        do_op(8'hF9, 8'd2, lat, b0);
        tests++;
        if ({lat == W, outs()} !== {1'b1, 8'hFD, 8'hFF, 4'b0010}) begin
            fails++; $display("FAIL post_reset_op: lat=%0d got %h required %h", lat, outs(),
                              {8'hFD, 8'hFF, 4'b0010});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_zero_dividend();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
